// File: rtl/lfsr_src_pkg.sv
// Shared types and constants for the LFSR sample source.
package lfsr_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int TAP0 = 0;
  localparam int TAP1 = 2;
  localparam int TAP2 = 3;
  localparam int TAP3 = 5;

  localparam logic [15:0] DEFAULT_SEED = 16'h0001;
  localparam logic [7:0]  BURST_CONT   = 8'd0;

  // An all-zero LFSR would lock up, so zero seeds map to the default.
  function automatic logic [15:0] coerce_seed(input logic [15:0] s);
    return (s == 16'h0000) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and advance; exposes the low DW bits.
// Load has priority over advance; zero seeds are coerced to the default seed.
module lfsr16
  import lfsr_src_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter int          DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [15:0]   load_val,
  input  logic          adv,
  output logic [DW-1:0] sample
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[TAP0] ^ lfsr_q[TAP1] ^ lfsr_q[TAP2] ^ lfsr_q[TAP3];
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = coerce_seed(load_val);
    end else if (adv) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= coerce_seed(SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sample = lfsr_q[DW-1:0];

endmodule

// File: rtl/lfsr_sample_source.sv
// Pseudo-random sample source: bursts of LFSR samples over valid/ready, stoppable and reseedable.
// All outputs are registered; a stalled beat holds d_out/d_valid until accepted.
module lfsr_sample_source
  import lfsr_src_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter int          DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    burst_len,
  input  logic          seed_load,
  input  logic [15:0]   seed,
  output logic [DW-1:0] d_out,
  output logic          d_valid,
  input  logic          d_ready,
  output logic          busy,
  output logic          done
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  len_q, len_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic        accept;
  logic [7:0]  cnt_inc;

  assign accept  = valid_q && d_ready;
  assign cnt_inc = cnt_q + 8'd1;

  lfsr16 #(
    .SEED (SEED),
    .DW   (DW)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .load_val (seed),
    .adv      (lfsr_adv),
    .sample   (d_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          if ((len_q != BURST_CONT) && (cnt_inc == len_q)) state_d = ST_IDLE;
          else if (stop)                                   state_d = ST_IDLE;
        end else if (stop) begin
          // The offered beat must still be delivered before the burst can end.
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    len_d     = len_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lfsr_load = seed_load;
        if (start && !stop) begin
          len_d = burst_len;
          cnt_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          lfsr_adv = 1'b1;
          cnt_d    = cnt_inc;
        end
      end
      ST_DRAIN: begin
        lfsr_adv = accept;
      end
      default: ;
    endcase
    done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    valid_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 8'd0;
      len_q   <= BURST_CONT;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign d_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_lfsr_sample_source.sv
// Scoreboard bench for lfsr_sample_source: stimulus pushes expected beats, a monitor pops on each accept.
module tb_lfsr_sample_source;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [7:0]  d_out;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] mdl;
  logic [7:0]  t1 [0:11] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h80, 8'h40, 8'h20};

  always #5 clk = ~clk;

  lfsr_sample_source dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .seed_load (seed_load),
    .seed      (seed),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .busy      (busy),
    .done      (done)
  );

  // Reference sequence: shift right, new MSB is the parity of taps 0,2,3,5.
  function automatic logic [15:0] mdl_step(input logic [15:0] x);
    logic fb;
    fb = ^(x & 16'h002D);
    return {fb, x[15:1]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_model(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mdl[7:0]);
      mdl = mdl_step(mdl);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready(input int mode, input int k);
    case (mode)
      0:       d_ready = 1'b1;
      1:       d_ready = ((k % 4) == 0) || ((k % 4) == 3);
      2:       d_ready = 1'($urandom_range(0, 1));
      default: d_ready = 1'b0;
    endcase
  endtask

  task automatic run_burst(input logic [7:0] len, input int mode, input bit sl_in_run, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    burst_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed_load = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", d_valid, 1);
    while (done_cnt == d0 && k < budget) begin
      drive_ready(mode, k);
      seed_load = sl_in_run && (k == 2);
      seed = 16'($urandom);
      tick();
      k++;
    end
    seed_load = 1'b0;
    d_ready = 1'b0;
    if (done_cnt == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL burst_timeout: no done after %0d cycles, expected done", budget);
    end else begin
      check("busy_after_done", busy, 0);
    end
    tick();
    tick();
    check("done_once", done_cnt - d0, 1);
  endtask

  // Monitor: scoreboard pops, stall stability and done-pulse shape.
  logic [7:0] prev_d = 8'd0;
  logic prev_stall = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", d_valid, 1);
        check("stall_hold_data", d_out, prev_d);
      end
      if (done) begin
        check("done_valid_low", d_valid, 0);
        check("done_single_cycle", prev_done, 0);
        done_cnt++;
      end
      if (d_valid && d_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL beat_unexpected: got 0x%0h, expected no beat", d_out);
        end else begin
          check("beat", d_out, exp_q.pop_front());
        end
      end
      prev_stall = d_valid && !d_ready;
      prev_d = d_out;
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int d0;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", d_out, 8'h01);
    check("rst_d_valid", d_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    mdl = 16'h0001;
    tick();

    // Fixed 12-beat burst, ready held high.
    for (int i = 0; i < 12; i++) exp_q.push_back(t1[i]);
    for (int i = 0; i < 12; i++) mdl = mdl_step(mdl);
    run_burst(8'd12, 0, 1'b0, 40);

    // Reseed to 1 and repeat with ready pattern 1,0,0,1.
    seed = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 12; i++) exp_q.push_back(t1[i]);
    mdl = 16'h0001;
    for (int i = 0; i < 12; i++) mdl = mdl_step(mdl);
    run_burst(8'd12, 1, 1'b0, 80);

    // Random bursts, random ready; longer ones also try seed_load in RUN.
    for (int b = 0; b < 6; b++) begin
      logic [7:0] len;
      len = 8'($urandom_range(1, 20));
      push_model(int'(len));
      run_burst(len, 2, (len >= 8'd6), 200);
    end

    // Zero seed is coerced to 1.
    seed = 16'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    exp_q.push_back(8'h01);
    mdl = mdl_step(16'h0001);
    push_model(2);
    run_burst(8'd3, 2, 1'b0, 100);

    // Seed load together with start: burst begins from the new seed.
    seed = 16'hACE1;
    seed_load = 1'b1;
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h70);
    mdl = mdl_step(mdl_step(16'hACE1));
    push_model(2);
    run_burst(8'd4, 0, 1'b0, 50);

    // start and stop together in IDLE: nothing happens.
    burst_len = 8'd5;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_valid", d_valid, 0);
    tick();
    check("startstop_valid_later", d_valid, 0);

    // seed_load during RUN is ignored.
    push_model(10);
    run_burst(8'd10, 1, 1'b1, 100);

    // Continuous mode: 300 beats, then stop on a stalled beat -> drain.
    a0 = acc_cnt;
    d0 = done_cnt;
    push_model(301);
    burst_len = 8'd0;
    start = 1'b1;
    d_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while ((acc_cnt - a0) < 300 && k < 400) begin
      tick();
      k++;
    end
    check("cont_beats_before_stop", acc_cnt - a0, 300);
    check("cont_no_done", done_cnt - d0, 0);
    d_ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    check("drain_busy", busy, 1);
    check("drain_valid", d_valid, 1);
    tick();
    start = 1'b0;
    tick();
    check("drain_still_busy", busy, 1);
    d_ready = 1'b1;
    k = 0;
    while (done_cnt == d0 && k < 10) begin
      tick();
      k++;
    end
    d_ready = 1'b0;
    tick();
    check("cont_total_beats", acc_cnt - a0, 301);
    check("cont_done_count", done_cnt - d0, 1);
    check("cont_busy_end", busy, 0);

    // Reset mid-burst after beat 5.
    d0 = done_cnt;
    a0 = acc_cnt;
    push_model(20);
    burst_len = 8'd20;
    start = 1'b1;
    d_ready = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while ((acc_cnt - a0) < 5 && k < 20) begin
      tick();
      k++;
    end
    check("rst_mid_beats", acc_cnt - a0, 5);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_valid", d_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_d_out", d_out, 8'h01);
    check("rst_mid_done", done, 0);
    exp_q.delete();
    d_ready = 1'b0;
    tick();
    tick();
    check("rst_mid_no_done", done_cnt - d0, 0);
    reset = 1'b1;
    tick();
    exp_q.push_back(8'h01);
    mdl = mdl_step(16'h0001);
    push_model(2);
    run_burst(8'd3, 2, 1'b0, 50);

    check("queue_empty", exp_q.size(), 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_sample_source.md
# lfsr_sample_source

Upstream stimulus stage for the three-sample running-sum block: it generates pseudo-random 8-bit samples from a 16-bit Fibonacci LFSR and delivers them over a valid/ready handshake. Its `d_out` drives the summer's `d` input. Bursts can be fixed-length or continuous, and the generator can be stopped, reseeded and restarted. The LFSR sequence matches the bench's reference model exactly, so the bench can compare against a software model.

## Interface
- `SEED`, default 16'h0001: LFSR value loaded at reset; a value of 0 is replaced by 16'h0001.
- `DW`, default 8: sample width; `d_out` = `lfsr[DW-1:0]`; DW ≤ 16.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `reset` input, 1 bit: **asynchronous, active-low** reset for all state.
- `start` input, 1 bit: begin a burst; sampled only in IDLE.
- `stop` input, 1 bit: end a burst early; sampled in RUN.
- `burst_len` input, 8 bits: beats per burst, latched on `start`; 0 means continuous.
- `seed_load` input, 1 bit: load `seed` into the LFSR; honoured only in IDLE.
- `seed` input, 16 bits: new seed; 0 is coerced to 16'h0001.
- `d_out` output, DW bits: current sample, equal to the low DW bits of the LFSR.
- `d_valid` output, 1 bit: `d_out` holds a beat awaiting acceptance.
- `d_ready` input, 1 bit: consumer accepts the beat when `d_valid && d_ready` at a clock edge.
- `busy` output, 1 bit: high while the FSM is not in IDLE.
- `done` output, 1 bit: one-cycle pulse when a burst ends, whether it completed or was stopped.

## Operation
- LFSR step on each accepted beat: `fb = l[0]^l[2]^l[3]^l[5]`, then `l <= {fb, l[15:1]}`. This is a maximal-length 16-bit sequence.
- FSM states are IDLE, RUN and DRAIN.
- In IDLE:
  - `d_valid` = 0.
  - `seed_load` loads the coerced seed.
  - On `start`: latch `burst_len`, clear `cnt`, go to RUN.
  - `start` and `seed_load` together: the seed loads and the burst starts from the new seed.
  - `start` and `stop` together: `stop` wins and the FSM stays in IDLE.
- In RUN:
  - `d_valid` = 1.
  - On each accept: advance the LFSR and increment the 8-bit `cnt`.
  - If the accept makes `cnt` equal to a nonzero `burst_len`: go to IDLE with `done` = 1.
- `stop` in RUN:
  - If the beat is accepted in the same cycle: go to IDLE and pulse `done`.
  - Otherwise: go to DRAIN. The pending beat is never dropped and `d_out` stays stable.
- In DRAIN: `d_valid` = 1; on accept, advance the LFSR, go to IDLE and pulse `done`. `start` and `stop` are ignored.
- Continuous mode (`burst_len`=0): `cnt` wraps at 255 to 0 without effect; the burst ends only via `stop`.
- The LFSR value persists across bursts. A new burst continues the sequence unless it is reseeded.
- Handshake rule: while `d_valid && !d_ready`, `d_out` and `d_valid` hold.
- `seed_load` outside IDLE is ignored.

## Timing
- Reset values:
  - LFSR = coerced `SEED`, so `d_out` = `SEED[DW-1:0]` (0x01 by default).
  - `d_valid` = 0, `busy` = 0, `done` = 0.
  - State = IDLE, `cnt` = 0.
- Reset asserted mid-burst returns everything to the reset values immediately. No `done` pulse is produced.
- `start` sampled at edge N: `d_valid` and `busy` are high after edge N; the first beat can be accepted at edge N+1.
- Throughput: one beat per cycle with `d_ready` held high. Samples are registered, with zero combinational path from `d_ready` to `d_out`.
- `done` is high for exactly the cycle after the final accepting edge, concurrent with `d_valid` = 0.
- All outputs are driven directly from registers.

## Structure
- Package `lfsr_src_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN),
  - the tap-position constants (0, 2, 3, 5),
  - the default seed 16'h0001,
  - the continuous-mode burst code 0.
- Sub-module `lfsr16` holds the 16-bit register with `load`/`load_val`/`adv` controls and zero-seed coercion. The top level owns the FSM, the beat counter and the handshake.

## Test plan
- Reset, then `start` with `burst_len`=12 and `d_ready`=1 → beats 0x01, 0x00×8, 0x80, 0x40, 0x20. `done` pulses once after the 12th beat, then `d_valid`=0 and `busy`=0.
- Same burst with `d_ready` toggled 1,0,0,1… → identical beat sequence, `d_out` stable across stalls, and no beat duplicated or skipped.
- `burst_len`=0 with `d_ready`=1 for 300 beats, then `stop` with a stalled beat → FSM enters DRAIN, the pending beat is delivered on the next `d_ready`, `done` pulses, and 301 beats are seen in total.
- In IDLE, `seed_load` with `seed`=16'h0000 → the first beat of the next burst is 0x01. With `seed`=16'hACE1, the first beat is 0xE1 and the second is 0x70.
- `start` and `stop` in the same IDLE cycle → stays IDLE with no `d_valid`. `seed_load` during RUN → ignored; the sequence continues unchanged.
- Reset pulsed low mid-burst at beat 5 → `d_valid` drops asynchronously, no `done` pulse, and the next burst starts again at 0x01.
